// File: rtl/mul_pkg.sv
// Shared types and build configuration for the sequential multiplier.
// Defining MUL_SIGNED_EN selects two's-complement operands and product.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

`ifdef MUL_SIGNED_EN
    localparam bit MUL_SIGNED = 1'b1;
`else
    localparam bit MUL_SIGNED = 1'b0;
`endif

endpackage

// File: rtl/mul_addsub_step.sv
// One combinational shift-add step of the multiplier: conditionally adds (or, in
// the signed build, subtracts) the shifted multiplicand into the accumulator.
module mul_addsub_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    input  logic [CW-1:0]      shift,
    input  logic               sub,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] mcand_ext;
    logic [2*WIDTH-1:0] addend;

    assign addend = mcand_ext << shift;

    generate
        if (MUL_SIGNED) begin : g_signed
            assign mcand_ext = {{WIDTH{mcand[WIDTH-1]}}, mcand};

            // The multiplier MSB carries negative weight, hence the subtract.
            always_comb begin
                acc_next = acc;
                if (mbit) begin
                    acc_next = sub ? (acc - addend) : (acc + addend);
                end
            end
        end else begin : g_unsigned
            logic unused_sub;
            assign unused_sub = sub;
            assign mcand_ext  = {{WIDTH{1'b0}}, mcand};

            always_comb begin
                acc_next = acc;
                if (mbit) begin
                    acc_next = acc + addend;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier with ready/valid on both sides, one step per cycle.
// Two's-complement operation is selected at build time with MUL_SIGNED_EN.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   Xin,
    input  logic [WIDTH-1:0]   Yin,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [2*WIDTH-1:0] Zout,
    output logic               o_valid,
    input  logic               o_ready,
    output logic               busy
);

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] zout_q, zout_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               last_step;

    assign last_step = (cnt_q == LAST_STEP);

    // The multiplier register shifts right each step, so bit 0 is always the current bit.
    mul_addsub_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .acc      (acc_q),
        .mcand    (x_q),
        .mbit     (y_q[0]),
        .shift    (cnt_q),
        .sub      (last_step),
        .acc_next (step_acc)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        zout_d  = zout_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = Xin;
                    y_d     = Yin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    zout_d  = step_acc;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            zout_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            zout_q  <= zout_d;
        end
    end

    assign i_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign Zout    = zout_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH=8): directed vectors, backpressure,
// busy-input, reset cases and random operands against an arithmetic model.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  Xin;
    logic [7:0]  Yin;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] Zout;
    logic        o_valid;
    logic        o_ready;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .Xin     (Xin),
        .Yin     (Yin),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .Zout    (Zout),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, p;
        if (MUL_SIGNED) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        p = sx * sy;
        return p[15:0];
    endfunction

    // Called at a negedge with the block idle; returns at a negedge after the output handshake.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                          input int hold, input bit poke, input string tag);
        int lat;
        check({tag, " i_ready_idle"}, i_ready, 1);
        Xin     = x;
        Yin     = y;
        i_valid = 1'b1;
        o_ready = (hold == 0);
        @(negedge clk);
        i_valid = 1'b0;
        Xin     = 8'($urandom);
        Yin     = 8'($urandom);
        check({tag, " busy_calc"}, busy, 1);
        check({tag, " i_ready_calc"}, i_ready, 0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            if (poke && lat == 3) begin
                i_valid = 1'b1;
                Xin     = 8'h11;
                Yin     = 8'h22;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        i_valid = 1'b0;
        check({tag, " latency"}, lat, 8);
        check({tag, " zout"}, Zout, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " zout_hold"}, Zout, exp);
            check({tag, " o_valid_hold"}, o_valid, 1);
            check({tag, " i_ready_hold"}, i_ready, 0);
        end
        o_ready = 1'b1;
        @(negedge clk);
        check({tag, " o_valid_drop"}, o_valid, 0);
        check({tag, " i_ready_back"}, i_ready, 1);
        check({tag, " busy_clear"}, busy, 0);
        o_ready = 1'b0;
        $display("op %s X=%02h Y=%02h Zout=%04h exp=%04h lat=%0d hold=%0d poke=%0d",
                 tag, x, y, Zout, exp, lat, hold, poke);
    endtask

    logic [7:0]  dir_x   [5];
    logic [7:0]  dir_y   [5];
    logic [15:0] dir_exp [5];

    initial begin
        int seen;
        logic [7:0] rx, ry;

        dir_x[0] = 8'hFF; dir_y[0] = 8'hFF; dir_exp[0] = MUL_SIGNED ? 16'h0001 : 16'hFE01;
        dir_x[1] = 8'h0C; dir_y[1] = 8'h0A; dir_exp[1] = 16'h0078;
        dir_x[2] = 8'h80; dir_y[2] = 8'h80; dir_exp[2] = 16'h4000;
        dir_x[3] = 8'h7F; dir_y[3] = 8'h80; dir_exp[3] = MUL_SIGNED ? 16'hC080 : 16'h3F80;
        dir_x[4] = 8'h03; dir_y[4] = 8'hFE; dir_exp[4] = MUL_SIGNED ? 16'hFFFA : 16'h02FA;

        // Reset held with i_valid high: nothing may be captured.
        rst     = 1'b1;
        i_valid = 1'b1;
        Xin     = 8'h5A;
        Yin     = 8'hA5;
        o_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        check("reset i_ready", i_ready, 1);
        check("reset o_valid", o_valid, 0);
        check("reset zout", Zout, 16'h0000);
        check("reset busy", busy, 0);
        $display("op reset i_ready=%0d o_valid=%0d Zout=%04h busy=%0d", i_ready, o_valid, Zout, busy);
        @(negedge clk);
        check("reset_no_capture busy", busy, 0);

        run_op(dir_x[0], dir_y[0], dir_exp[0], 0, 1'b0, "dir0");
        run_op(dir_x[1], dir_y[1], dir_exp[1], 5, 1'b0, "dir1_bp5");
        run_op(dir_x[2], dir_y[2], dir_exp[2], 0, 1'b1, "dir2_poke");
        run_op(dir_x[3], dir_y[3], dir_exp[3], 2, 1'b0, "dir3");
        run_op(dir_x[4], dir_y[4], dir_exp[4], 0, 1'b0, "dir4");

        // Reset during CALC just before step 4.
        Xin     = 8'hFF;
        Yin     = 8'hFF;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset i_ready", i_ready, 1);
        check("midreset busy", busy, 0);
        check("midreset o_valid", o_valid, 0);
        check("midreset zout", Zout, 16'h0000);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        check("midreset no_o_valid", seen, 0);
        $display("op midreset o_valid_pulses=%0d", seen);

        for (int n = 0; n < 20; n++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op(rx, ry, model(rx, ry), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
